// File: rtl/sprite_rom_scheduler_if.sv
// Sprite-table configuration bus between game logic (master) and the
// sprite scheduler (slave). cfg_pending reports uncommitted shadow writes.
interface sprite_rom_scheduler_if #(
  parameter int NUM_SPR = 4,
  parameter int NUM_IMG = 8
);
  localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int IMG_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;

  logic              cfg_we;
  logic [SLOT_W-1:0] cfg_idx;
  logic              cfg_en;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic [IMG_W-1:0]  cfg_img;
  logic              cfg_pending;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_img,
    input  cfg_pending
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_img,
    output cfg_pending
  );
endinterface

// File: rtl/sprite_rom_scheduler.sv
// Sprite ROM scheduler: per pixel, selects the highest-priority enabled
// sprite covering (DrawX, DrawY), addresses the shared sprite ROM, and
// registers the returned palette index with a transparency-qualified hit.
// The sprite table is double-buffered; writes land in a shadow copy that is
// committed to the active copy on frame_start so a frame never tears.
module sprite_rom_scheduler #(
  parameter int NUM_SPR = 4,
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int NUM_IMG = 8,
  parameter int ADDR_W  = 13,
  parameter int IDX_W   = 4
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic                      blank,
  sprite_rom_scheduler_if.slave     cfg,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [IDX_W-1:0]          rom_q,
  output logic                      spr_hit,
  output logic [((NUM_SPR > 1) ? $clog2(NUM_SPR) : 1)-1:0] spr_slot,
  output logic [IDX_W-1:0]          spr_index
);
  localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int IMG_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
  localparam int XB     = $clog2(SPR_W);
  localparam int YB     = $clog2(SPR_H);
  localparam logic [9:0] SPR_W10 = 10'(SPR_W);
  localparam logic [9:0] SPR_H10 = 10'(SPR_H);

  typedef struct packed {
    logic             en;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [IMG_W-1:0] img;
  } entry_t;

  entry_t shadow [NUM_SPR];
  entry_t active [NUM_SPR];
  entry_t wr_entry;

  logic [NUM_SPR-1:0] wr_sel;
  logic [NUM_SPR-1:0] hit;
  logic [ADDR_W-1:0]  slot_addr [NUM_SPR];

  logic               any_hit;
  logic [SLOT_W-1:0]  sel;

  // Pipeline stage-0 registers (slot and valid travel with rom_address)
  logic               v0_reg;
  logic [SLOT_W-1:0]  slot0_reg;

  assign wr_entry = '{en: cfg.cfg_en, x: cfg.cfg_x, y: cfg.cfg_y, img: cfg.cfg_img};

  // Per-slot write decode, hit test and image-relative ROM address.
  // The 10-bit unsigned differences wrap for pixels left of / above the
  // sprite, so a single "< size" compare covers both bounds and never wraps
  // a sprite around the screen edge.
  generate
    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_slot
      logic [9:0] dx;
      logic [9:0] dy;
      assign wr_sel[gi]    = cfg.cfg_we && (cfg.cfg_idx == SLOT_W'(gi));
      assign dx            = DrawX - active[gi].x;
      assign dy            = DrawY - active[gi].y;
      assign hit[gi]       = active[gi].en && (dx < SPR_W10) && (dy < SPR_H10);
      // Power-of-two sizes make img*W*H + dy*W + dx a plain bit concatenation
      assign slot_addr[gi] = ADDR_W'({active[gi].img, dy[YB-1:0], dx[XB-1:0]});
    end
  endgenerate

  // Priority encoder: lowest-numbered hitting slot wins
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel     = SLOT_W'(i);
      end
    end
  end

  // Shadow/active sprite tables; a write coinciding with frame_start is
  // forwarded straight into the commit
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (wr_sel[i]) begin
          shadow[i] <= wr_entry;
        end
        if (frame_start) begin
          active[i] <= wr_sel[i] ? wr_entry : shadow[i];
        end
      end
    end
  end

  // Pending flag: set by a write, cleared by the commit (commit wins)
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      cfg.cfg_pending <= 1'b0;
    end else if (frame_start) begin
      cfg.cfg_pending <= 1'b0;
    end else if (cfg.cfg_we) begin
      cfg.cfg_pending <= 1'b1;
    end
  end

  // Stage 0: register ROM address, valid and winning slot
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_address <= '0;
      v0_reg      <= 1'b0;
      slot0_reg   <= '0;
    end else begin
      rom_address <= any_hit ? slot_addr[sel] : '0;
      v0_reg      <= any_hit && blank;
      slot0_reg   <= sel;
    end
  end

  // Stage 1: capture ROM data; index 0 is transparent and does not fall
  // through to a lower-priority sprite
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      spr_hit   <= 1'b0;
      spr_slot  <= '0;
      spr_index <= '0;
    end else begin
      spr_index <= rom_q;
      spr_slot  <= slot0_reg;
      spr_hit   <= v0_reg && (rom_q != '0);
    end
  end

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Directed bench for sprite_rom_scheduler. The ROM stub returns image+1 as
// palette index for every pixel of an image, except image 7 which is fully
// transparent (index 0).
module tb_sprite_rom_scheduler;
  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        blank = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [12:0] rom_address;
  logic [3:0]  rom_q = '0;
  logic        spr_hit;
  logic [1:0]  spr_slot;
  logic [3:0]  spr_index;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] addr_seen;
  logic        hist [10];

  sprite_rom_scheduler_if #(.NUM_SPR(4), .NUM_IMG(8)) cfg_bus ();

  sprite_rom_scheduler #(
    .NUM_SPR(4), .SPR_W(32), .SPR_H(32), .NUM_IMG(8), .ADDR_W(13), .IDX_W(4)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .cfg         (cfg_bus),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .spr_hit     (spr_hit),
    .spr_slot    (spr_slot),
    .spr_index   (spr_index)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM stub clocked on the falling edge
  always @(negedge vga_clk) begin
    if (rom_address[12:10] == 3'd7) rom_q <= 4'd0;
    else                            rom_q <= {1'b0, rom_address[12:10]} + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [9:0] x,
                           input logic [9:0] y, input logic [2:0] img, input logic with_frame);
    cfg_bus.cfg_idx = idx;
    cfg_bus.cfg_en  = en;
    cfg_bus.cfg_x   = x;
    cfg_bus.cfg_y   = y;
    cfg_bus.cfg_img = img;
    cfg_bus.cfg_we  = 1'b1;
    frame_start     = with_frame;
    @(posedge vga_clk); #1;
    cfg_bus.cfg_we  = 1'b0;
    frame_start     = 1'b0;
    $display("cfg  slot=%0d en=%0d x=%0d y=%0d img=%0d frame=%0d pending=%0d",
             idx, en, x, y, img, with_frame, cfg_bus.cfg_pending);
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    $display("frame commit pending=%0d", cfg_bus.cfg_pending);
  endtask

  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
    @(posedge vga_clk); #1;
    addr_seen = rom_address;
    @(posedge vga_clk); #1;
    $display("px   (%0d,%0d) blank=%0d addr=%0d hit=%0d slot=%0d index=%0d",
             x, y, b, addr_seen, spr_hit, spr_slot, spr_index);
  endtask

  initial begin
    cfg_bus.cfg_we  = 1'b0;
    cfg_bus.cfg_idx = '0;
    cfg_bus.cfg_en  = 1'b0;
    cfg_bus.cfg_x   = '0;
    cfg_bus.cfg_y   = '0;
    cfg_bus.cfg_img = '0;

    // Power-up reset
    repeat (2) @(posedge vga_clk);
    #1 reset_n = 1'b1;
    @(posedge vga_clk); #1;

    // Pending write then reset mid-line discards it
    DrawX = 10'd300; DrawY = 10'd100; blank = 1'b1;
    cfg_write(2'd1, 1'b1, 10'd100, 10'd50, 3'd2, 1'b0);
    chk("pending_before_reset", cfg_bus.cfg_pending, 1);
    reset_n = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("reset_index", spr_index, 0);
    reset_n = 1'b1;
    @(posedge vga_clk); #1;
    chk("reset_pending", cfg_bus.cfg_pending, 0);
    chk("reset_hit", spr_hit, 0);
    chk("reset_slot", spr_slot, 0);
    chk("reset_addr", rom_address, 0);
    repeat (3) @(posedge vga_clk);
    #1 chk("reset_pending_stays", cfg_bus.cfg_pending, 0);
    new_frame();
    pixel(10'd100, 10'd50, 1'b1);
    chk("reset_discard_hit", spr_hit, 0);

    // Shadowing: mid-frame write is invisible until the commit
    cfg_write(2'd1, 1'b1, 10'd100, 10'd50, 3'd2, 1'b0);
    chk("shadow_pending", cfg_bus.cfg_pending, 1);
    pixel(10'd100, 10'd50, 1'b1);
    chk("shadow_hit", spr_hit, 0);
    chk("shadow_addr", addr_seen, 0);
    new_frame();
    chk("commit_pending", cfg_bus.cfg_pending, 0);
    pixel(10'd100, 10'd50, 1'b1);
    chk("tl_addr", addr_seen, 2048);
    chk("tl_hit", spr_hit, 1);
    chk("tl_slot", spr_slot, 1);
    chk("tl_index", spr_index, 3);
    pixel(10'd131, 10'd81, 1'b1);
    chk("br_addr", addr_seen, 3071);
    chk("br_hit", spr_hit, 1);
    pixel(10'd132, 10'd81, 1'b1);
    chk("right_out_hit", spr_hit, 0);
    pixel(10'd99, 10'd50, 1'b1);
    chk("left_out_hit", spr_hit, 0);

    // Screen edges
    cfg_write(2'd3, 1'b1, 10'd620, 10'd10, 3'd1, 1'b0);
    cfg_write(2'd2, 1'b1, 10'd0, 10'd300, 3'd4, 1'b0);
    new_frame();
    pixel(10'd619, 10'd20, 1'b1);
    chk("edge_619_hit", spr_hit, 0);
    pixel(10'd639, 10'd20, 1'b1);
    chk("edge_639_addr", addr_seen, 1363);
    chk("edge_639_hit", spr_hit, 1);
    chk("edge_639_slot", spr_slot, 3);
    chk("edge_639_index", spr_index, 2);
    pixel(10'd5, 10'd20, 1'b1);
    chk("edge_nowrap_hit", spr_hit, 0);
    pixel(10'd0, 10'd300, 1'b1);
    chk("edge_x0_addr", addr_seen, 4096);
    chk("edge_x0_hit", spr_hit, 1);
    chk("edge_x0_slot", spr_slot, 2);

    // Priority between overlapping slots 0 and 2
    cfg_write(2'd0, 1'b1, 10'd190, 10'd190, 3'd3, 1'b0);
    cfg_write(2'd2, 1'b1, 10'd195, 10'd195, 3'd5, 1'b0);
    new_frame();
    pixel(10'd200, 10'd200, 1'b1);
    chk("prio_addr", addr_seen, 3402);
    chk("prio_slot", spr_slot, 0);
    chk("prio_index", spr_index, 4);
    chk("prio_hit", spr_hit, 1);

    // Transparent higher-priority pixel does not fall through
    cfg_write(2'd0, 1'b1, 10'd190, 10'd190, 3'd7, 1'b0);
    new_frame();
    pixel(10'd200, 10'd200, 1'b1);
    chk("transp_hit", spr_hit, 0);
    chk("transp_slot", spr_slot, 0);
    pixel(10'd225, 10'd225, 1'b1);
    chk("slot2_only_slot", spr_slot, 2);
    chk("slot2_only_index", spr_index, 6);
    chk("slot2_only_hit", spr_hit, 1);

    // Blanking suppresses the hit
    pixel(10'd225, 10'd225, 1'b0);
    chk("blank_hit", spr_hit, 0);
    chk("blank_addr", addr_seen, 6110);

    // Latency: DrawX steps into slot 2 (x=195) along row 224
    pixel(10'd190, 10'd224, 1'b1);
    for (int k = 0; k < 10; k++) begin
      DrawX = 10'(190 + k);
      @(posedge vga_clk); #1;
      hist[k] = spr_hit;
      $display("step DrawX=%0d spr_hit=%0d", 190 + k, spr_hit);
    end
    chk("latency_before", hist[5], 0);
    chk("latency_enter", hist[6], 1);
    chk("latency_after", hist[9], 1);

    // Write coinciding with frame_start takes effect immediately
    cfg_write(2'd3, 1'b1, 10'd400, 10'd400, 3'd6, 1'b1);
    chk("simul_pending", cfg_bus.cfg_pending, 0);
    pixel(10'd400, 10'd400, 1'b1);
    chk("simul_addr", addr_seen, 6144);
    chk("simul_hit", spr_hit, 1);
    chk("simul_slot", spr_slot, 3);
    chk("simul_index", spr_index, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_scheduler.md
Name: sprite_rom_scheduler

Overview:
- Shares one sprite ROM and its palette index path among NUM_SPR on-screen objects: player jet, enemy jets, bullets.
- Per VGA pixel, picks the highest-priority enabled sprite covering (DrawX, DrawY) and generates the ROM address into that sprite's image.
- Registers the returned palette index and flags transparency for the color mux downstream.
- Game-logic writes to the sprite table are shadowed and committed atomically at frame start, so no tearing occurs mid-frame.

Parameters:
- NUM_SPR, 4, number of sprite slots; slot 0 has the highest priority.
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels (power of two).
- NUM_IMG, 8, number of images stored back-to-back in the ROM.
- ADDR_W, 13, ROM address width; must satisfy NUM_IMG*SPR_W*SPR_H <= 2^ADDR_W.
- IDX_W, 4, palette index width (ROM q width).

Ports:
- vga_clk  in  1  pixel clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at DrawX=0, DrawY=0.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank  in  1  high = visible pixel (active-display qualifier).
- cfg_we  in  1  sprite-table write strobe.
- cfg_idx  in  log2(NUM_SPR)  slot being written.
- cfg_en  in  1  slot enable.
- cfg_x  in  10  sprite top-left X.
- cfg_y  in  10  sprite top-left Y.
- cfg_img  in  log2(NUM_IMG)  image number.
- cfg_pending  out  1  shadow table holds uncommitted writes.
- rom_address  out  ADDR_W  address to the shared ROM, which is clocked on ~vga_clk.
- rom_q  in  IDX_W  ROM data.
- spr_hit  out  1  pixel is covered by an opaque sprite pixel.
- spr_slot  out  log2(NUM_SPR)  winning slot.
- spr_index  out  IDX_W  palette index to drive into the palette.

Behaviour:
- Reset (reset_n=0 at posedge):
  - All shadow and active table entries cleared (en=0, x=y=img=0).
  - cfg_pending=0, rom_address=0, spr_hit=0, spr_slot=0, spr_index=0.
  - Pipeline valid bits cleared.
  - Reset mid-frame also discards pending writes.
- Config writes:
  - cfg_we=1 writes {cfg_en, cfg_x, cfg_y, cfg_img} into shadow[cfg_idx] and sets cfg_pending=1.
  - Multiple writes per frame allowed; last write to a slot wins.
- Commit:
  - On frame_start, active table <= shadow table and cfg_pending <= 0.
  - If cfg_we and frame_start coincide, the write lands in shadow, is included in this commit, and cfg_pending stays 0. Write-through to the commit takes priority over clearing.
- Stage 0 (posedge t, using DrawX/DrawY at t):
  - Hit test per slot: en && DrawX-x < SPR_W && DrawY-y < SPR_H.
  - Subtraction is 10-bit unsigned, so a pixel left of or above the sprite wraps and fails the test.
  - Sprites overlapping the right/bottom screen edge are clipped naturally; no wrap to x=0.
  - Priority encoder selects the lowest matching slot.
  - rom_address <= img*SPR_W*SPR_H + (DrawY-y)*SPR_W + (DrawX-x), computed in ADDR_W bits.
  - Registered alongside: v0=any_hit&&blank, slot0.
  - No hit: rom_address <= 0, v0=0.
- ROM read: the ROM samples rom_address on the following negedge; rom_q is stable before posedge t+1.
- Stage 1 (posedge t+1):
  - spr_index <= rom_q and spr_slot <= slot0.
  - spr_hit <= v0 && rom_q != 0. Index 0 is transparent.
  - A transparent pixel of a higher-priority sprite does NOT fall through to a lower slot; spr_hit=0 and background shows.
- Latency: exactly 2 vga_clk posedges from DrawX/DrawY to spr_hit/spr_index. The caller delays background color by the same amount.
- blank=0: spr_hit forced 0 two cycles later. rom_address is still generated (don't-care).
- The active table never changes except at frame_start or reset.

Test Plan:
- Reset: reset_n=0 for 2 cycles mid-line with cfg_pending=1 -> all outputs 0 and cfg_pending=0 one cycle after release; stays clear until the next write.
- Shadowing:
  - Write slot1 {en=1, x=100, y=50, img=2} mid-frame -> cfg_pending=1 and no hit at (100,50) this frame.
  - After frame_start, pixel (100,50) gives rom_address=2048 one cycle later.
  - Pixel (131,81) gives rom_address=3071.
- Edges:
  - Sprite at x=620: pixel (619,y) gives no hit; (639,y) hits with column offset 19.
  - Sprite at x=0: pixel (0,y) hits; no wrap from the right edge.
- Priority/transparency:
  - Slots 0 and 2 overlap at (200,200) -> spr_slot=0.
  - Same with slot 0 returning rom_q=0 -> spr_hit=0, not slot 2.
- Latency/blank:
  - Hit asserted with DrawX stepping each cycle -> spr_hit transitions exactly 2 cycles after DrawX enters the sprite.
  - blank=0 on an in-sprite pixel -> spr_hit=0.
- Simultaneous: cfg_we with frame_start -> entry active immediately and cfg_pending=0 on the next cycle.
